// File: rtl/serial_ha_adder.sv
// serial_ha_adder -- bit-serial WIDTH-bit adder built from NAND half-adder cells.
//
// One operand bit pair is added per clock. Two Half_adder_nand cells plus an OR
// form a full-adder slice that is fed from the low bits of the operand shift
// registers and a carry register. A start/busy/done handshake frames each
// operation; the result is held until the next completion.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only in IDLE or DONE
//   A, B   in   WIDTH  operands, captured on the accepted start edge
//   Cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse when a new result is available
//   Sum    out  WIDTH  registered result
//   Cout   out  1      registered carry-out

module Half_adder_nand (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);
    logic n1;
    logic n2;
    logic n3;

    // Classic four-NAND XOR; the shared first NAND also yields the carry.
    assign n1    = ~(A & B);
    assign n2    = ~(A & n1);
    assign n3    = ~(B & n1);
    assign Sum   = ~(n2 & n3);
    assign Carry = ~n1;
endmodule

module serial_ha_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               ha1_sum;
    logic               ha1_carry;
    logic               bit_sum;
    logic               ha2_carry;
    logic               carry_next;
    logic               last_bit;
    logic               accept;

    // Full-adder slice on the current least-significant bit pair.
    Half_adder_nand ha1 (
        .A     (op_a[0]),
        .B     (op_b[0]),
        .Sum   (ha1_sum),
        .Carry (ha1_carry)
    );

    Half_adder_nand ha2 (
        .A     (ha1_sum),
        .B     (carry),
        .Sum   (bit_sum),
        .Carry (ha2_carry)
    );

    assign carry_next = ha1_carry | ha2_carry;
    // Each new sum bit enters at the top so that after WIDTH shifts bit 0 sits at res[0].
    assign res_next   = {bit_sum, res[WIDTH-1:1]};
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign accept     = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done are flopped copies of the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == RUN);
            done  <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= A;
            op_b  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            res   <= res_next;
            carry <= carry_next;
            cnt   <= cnt + CNT_W'(1);
            // Publish on the final bit so the outputs only move on entry to DONE.
            if (last_bit) begin
                Sum  <= res_next;
                Cout <= carry_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_ha_adder.sv
// tb_serial_ha_adder -- self-checking bench for serial_ha_adder (WIDTH=8).
//
// Directed steps followed by randomized operations; expected results come from
// plain integer addition of the operands.

module tb_serial_ha_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_ha_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with start low: controls quiet, result held.
    task automatic idle_cycle(input string tag);
        start = 1'b0;
        tick;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_sum"},  64'(sum),  64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    endtask

    // Launch one addition from IDLE or DONE and follow it to the done pulse.
    // mess_at > 0: at that RUN cycle drive start=1 and new operands, which must be ignored.
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input int mess_at);
        logic [W:0] r;
        r     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        chk({tag, "_done0"}, 64'(done), 64'd0);
        for (int i = 1; i < W; i++) begin
            if (i == mess_at) begin
                a     = 8'h01;
                b     = 8'h01;
                cin   = 1'($urandom_range(1, 0));
                start = 1'b1;
            end
            tick;
            chk({tag, "_busy_run"}, 64'(busy), 64'd1);
            chk({tag, "_done_run"}, 64'(done), 64'd0);
            chk({tag, "_sum_hold"}, 64'(sum),  64'(exp_sum));
            chk({tag, "_cout_hold"}, 64'(cout), 64'(exp_cout));
        end
        start = 1'b0;
        tick;
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_sum"},  64'(sum),  64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;

        // Reset
        tick;
        tick;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        repeat (3) idle_cycle("idle_after_rst");

        // Basic operation and carry boundaries
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b1, 0);
        idle_cycle("post_5a_3c");
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 0);
        idle_cycle("post_ff_01");
        do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 0);
        idle_cycle("post_ff_ff");

        // start during RUN ignored
        do_op("ignore_run", 8'hA5, 8'h5A, 1'b0, 3);
        idle_cycle("post_ignore");

        // Back-to-back through DONE
        do_op("b2b_first", 8'h77, 8'h11, 1'b0, 0);
        do_op("b2b_second", 8'h10, 8'h20, 1'b0, 0);
        idle_cycle("post_b2b");

        // Randomized operations, randomly back-to-back or separated
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            logic         rc;
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            do_op("rand", rx, ry, rc, (k % 3 == 0) ? int'($urandom_range(W - 1, 1)) : 0);
            if ($urandom_range(1, 0) == 1) idle_cycle("rand_idle");
        end
        idle_cycle("post_rand");

        // Reset in the middle of RUN
        a     = 8'h33;
        b     = 8'h44;
        cin   = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        chk("abort_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        tick;
        rst      = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        repeat (W + 2) idle_cycle("abort_quiet");
        do_op("after_abort", 8'h01, 8'h02, 1'b0, 0);
        idle_cycle("post_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
